// File: rtl/board_pkg.sv
// Shared board-level constants for the slide-switch front end.
// Also holds the helper that sizes the per-bit stability counters.
package board_pkg;

  localparam int unsigned DEFAULT_SW_WIDTH      = 10;
  localparam int unsigned CLK_HZ                = 50_000_000;
  localparam int unsigned DEFAULT_STABLE_CYCLES = 500_000;

  // Counter width able to hold 0..cycles-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: two-flop synchronizer, stability counter and accepted level.
// accept_c flags the edge on which sw_db takes the synchronized level.
module debounce_bit
  import board_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic sw_db,
  output logic accept_c
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 32'd1);

  logic          q1;
  logic          q2;
  logic [CW-1:0] cnt;

  // Level has differed for STABLE_CYCLES consecutive edges once the count is full.
  assign accept_c = (q2 != sw_db) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      q1    <= 1'b0;
      q2    <= 1'b0;
      cnt   <= '0;
      sw_db <= 1'b0;
    end else begin
      q1 <= sw;
      q2 <= q1;
      if (q2 == sw_db) begin
        cnt <= '0;
      end else if (accept_c) begin
        cnt   <= '0;
        sw_db <= q2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Parallel slide-switch debouncer with optional rise/fall pulse outputs.
// Define SWITCH_DEBOUNCE_EDGE_EN to build the edge-pulse registers; otherwise they read 0.
module switch_debouncer
  import board_pkg::*;
#(
  parameter int unsigned WIDTH         = DEFAULT_SW_WIDTH,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  logic [WIDTH-1:0] accept_c;

  generate
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      debounce_bit #(
        .STABLE_CYCLES(STABLE_CYCLES)
      ) u_bit (
        .clk     (clk),
        .reset   (reset),
        .sw      (SW[i]),
        .sw_db   (sw_db[i]),
        .accept_c(accept_c[i])
      );
    end
  endgenerate

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  // Pulse direction follows the level being left on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= accept_c & ~sw_db;
      sw_fall <= accept_c &  sw_db;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = ^accept_c;
  assign sw_rise       = '0;
  assign sw_fall       = '0;
`endif

endmodule
